// File: rtl/power_meter_pkg.sv
// Shared types, constants and helpers for the multichannel power meter.
package power_meter_pkg;

  localparam real ZERO_R = 0.0;

  // Smallest channel-index width that can address n channels (at least 1 bit).
  function automatic int unsigned ch_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  // Larger of two reals; used for the running peak.
  function automatic real max_r(input real a, input real b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multichannel_power_meter_ohm_stage.sv
// Stage 1: registered Ohm's-law current and instantaneous power per sample.
module ohm_stage
  import power_meter_pkg::*;
#(
  parameter int unsigned CH_W       = 2,
  parameter real         RESISTANCE = 100.0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [CH_W-1:0] in_chan,
  input  real             voltage_in,
  output logic            smp_valid,
  output logic [CH_W-1:0] smp_chan,
  output real             voltage_out,
  output real             current_out,
  output real             power_out
);

  // Register I = V/R and P = V*I; real outputs hold between samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_valid   <= 1'b0;
      smp_chan    <= '0;
      voltage_out <= ZERO_R;
      current_out <= ZERO_R;
      power_out   <= ZERO_R;
    end else if (clear) begin
      smp_valid <= 1'b0;
    end else begin
      smp_valid <= in_valid;
      if (in_valid) begin
        smp_chan    <= in_chan;
        voltage_out <= voltage_in;
        current_out <= voltage_in / RESISTANCE;
        power_out   <= voltage_in * (voltage_in / RESISTANCE);
      end
    end
  end

endmodule

// File: rtl/multichannel_power_meter.sv
// N-channel resistive-load power meter with per-channel windowed statistics.
module multichannel_power_meter
  import power_meter_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = ch_width(NUM_CH),
  parameter int unsigned WINDOW     = 100,
  parameter real         RESISTANCE = 100.0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [CH_W-1:0] in_chan,
  input  real             voltage_in,
  output logic            smp_valid,
  output logic [CH_W-1:0] smp_chan,
  output real             current_out,
  output real             power_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CH_W-1:0] res_chan,
  output real             avg_power,
  output real             rms_voltage,
  output real             peak_power,
  output logic            err_chan,
  output logic            overrun
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  logic             chan_ok;
  logic             s1_valid;
  real              s1_volt;
  real              sum_p  [NUM_CH];
  real              sum_v2 [NUM_CH];
  real              peak   [NUM_CH];
  logic [CNT_W-1:0] cnt    [NUM_CH];
  real              acc_p, acc_v2, acc_pk;
  logic             done;

  assign chan_ok  = 32'(in_chan) < NUM_CH;
  assign s1_valid = in_valid && chan_ok;

  ohm_stage #(
    .CH_W       (CH_W),
    .RESISTANCE (RESISTANCE)
  ) u_ohm (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .in_valid    (s1_valid),
    .in_chan     (in_chan),
    .voltage_in  (voltage_in),
    .smp_valid   (smp_valid),
    .smp_chan    (smp_chan),
    .voltage_out (s1_volt),
    .current_out (current_out),
    .power_out   (power_out)
  );

  // Next accumulator values for the channel of the current stage-1 sample.
  always_comb begin
    acc_p  = sum_p[smp_chan] + power_out;
    acc_v2 = sum_v2[smp_chan] + s1_volt * s1_volt;
    acc_pk = max_r(peak[smp_chan], power_out);
    done   = smp_valid && (cnt[smp_chan] == CNT_W'(WINDOW - 1));
  end

  // Per-channel accumulators; a completing channel restarts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sum_p[i]  <= ZERO_R;
        sum_v2[i] <= ZERO_R;
        peak[i]   <= ZERO_R;
        cnt[i]    <= '0;
      end
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sum_p[i]  <= ZERO_R;
        sum_v2[i] <= ZERO_R;
        peak[i]   <= ZERO_R;
        cnt[i]    <= '0;
      end
    end else if (smp_valid) begin
      if (done) begin
        sum_p[smp_chan]  <= ZERO_R;
        sum_v2[smp_chan] <= ZERO_R;
        peak[smp_chan]   <= ZERO_R;
        cnt[smp_chan]    <= '0;
      end else begin
        sum_p[smp_chan]  <= acc_p;
        sum_v2[smp_chan] <= acc_v2;
        peak[smp_chan]   <= acc_pk;
        cnt[smp_chan]    <= cnt[smp_chan] + 1'b1;
      end
    end
  end

  // Result register with valid/ready hold, drop-on-busy and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid   <= 1'b0;
      res_chan    <= '0;
      avg_power   <= ZERO_R;
      rms_voltage <= ZERO_R;
      peak_power  <= ZERO_R;
      err_chan    <= 1'b0;
      overrun     <= 1'b0;
    end else if (clear) begin
      res_valid   <= 1'b0;
      res_chan    <= '0;
      avg_power   <= ZERO_R;
      rms_voltage <= ZERO_R;
      peak_power  <= ZERO_R;
      err_chan    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (in_valid && !chan_ok) err_chan <= 1'b1;
      // Acceptance and a new completion on the same edge load back-to-back.
      if (done && (!res_valid || res_ready)) begin
        res_valid   <= 1'b1;
        res_chan    <= smp_chan;
        avg_power   <= acc_p / real'(WINDOW);
        rms_voltage <= $sqrt(acc_v2 / real'(WINDOW));
        peak_power  <= acc_pk;
      end else begin
        if (done) overrun <= 1'b1;
        if (res_valid && res_ready) begin
          res_valid   <= 1'b0;
          res_chan    <= '0;
          avg_power   <= ZERO_R;
          rms_voltage <= ZERO_R;
          peak_power  <= ZERO_R;
        end
      end
    end
  end

endmodule
